id_ex_segreg: RTL and testbench

ID/EX pipeline segment register for the five-stage core. It captures decoded instruction state from ID and presents it to EX, where the forwarding unit and the ALU operand muxes consume `rf_ra0_ex`, `rf_ra1_ex`, `rf_rd0_ex` and `rf_rd1_ex`. The block also detects load-use hazards, stalls IF/ID, and inserts exactly one bubble per hazard. It honours branch flushes and the debug enable, and optionally keeps bubble and flush counters.

---
 rtl/id_ex_segreg.sv | 137 +++++++++++++
 tb/tb_id_ex_segreg.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_segreg.sv
// ID/EX pipeline segment register with load-use hazard detection and bubble insertion.
// Optional bubble/flush performance counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_segreg #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] pc_id,
  input  logic [31:0] inst_id,
  input  logic        rf_re0_id,
  input  logic        rf_re1_id,
  input  logic [4:0]  rf_ra0_id,
  input  logic [4:0]  rf_ra1_id,
  input  logic [4:0]  rf_wa_id,
  input  logic        rf_we_id,
  input  logic        mem_re_id,
  input  logic [31:0] rf_rd0_id,
  input  logic [31:0] rf_rd1_id,
  input  logic [31:0] imm_id,
  input  logic [15:0] ctrl_id,
  output logic        valid_ex,
  output logic [31:0] pc_ex,
  output logic [31:0] inst_ex,
  output logic [4:0]  rf_ra0_ex,
  output logic [4:0]  rf_ra1_ex,
  output logic [4:0]  rf_wa_ex,
  output logic        rf_we_ex,
  output logic        mem_re_ex,
  output logic [31:0] rf_rd0_ex,
  output logic [31:0] rf_rd1_ex,
  output logic [31:0] imm_ex,
  output logic [15:0] ctrl_ex,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0] bubble_cnt,
  output logic [31:0] flush_cnt,
`endif
  output logic        stall_if_id
);

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [4:0]  r_ra0;
  logic [4:0]  r_ra1;
  logic [4:0]  r_wa;
  logic        r_we;
  logic        r_mem_re;
  logic [31:0] r_rd0;
  logic [31:0] r_rd1;
  logic [31:0] r_imm;
  logic [15:0] r_ctrl;

  logic w_src0_hit;
  logic w_src1_hit;
  logic w_lu;
  logic w_load_bubble;
  logic w_capture;

  // A load in EX whose non-x0 destination feeds a source ID really reads.
  assign w_src0_hit = rf_re0_id && (rf_ra0_id == r_wa);
  assign w_src1_hit = rf_re1_id && (rf_ra1_id == r_wa);
  assign w_lu       = r_valid && r_mem_re && r_we && (r_wa != 5'd0) &&
                      (w_src0_hit || w_src1_hit);

  // Flush wins over the stall since IF/ID is being discarded anyway.
  assign stall_if_id = !rst && en && w_lu && !flush;

  assign w_load_bubble = rst || (en && (flush || w_lu));
  assign w_capture     = !rst && en && !flush && !w_lu;

  always_ff @(posedge clk) begin
    if (w_load_bubble) begin
      r_valid  <= 1'b0;
      r_pc     <= 32'd0;
      r_inst   <= NOP_INST;
      r_ra0    <= 5'd0;
      r_ra1    <= 5'd0;
      r_wa     <= 5'd0;
      r_we     <= 1'b0;
      r_mem_re <= 1'b0;
      r_rd0    <= 32'd0;
      r_rd1    <= 32'd0;
      r_imm    <= 32'd0;
      r_ctrl   <= 16'd0;
    end else if (w_capture) begin
      r_valid  <= 1'b1;
      r_pc     <= pc_id;
      r_inst   <= inst_id;
      r_ra0    <= rf_ra0_id;
      r_ra1    <= rf_ra1_id;
      r_wa     <= rf_wa_id;
      r_we     <= rf_we_id;
      r_mem_re <= mem_re_id;
      r_rd0    <= rf_rd0_id;
      r_rd1    <= rf_rd1_id;
      r_imm    <= imm_id;
      r_ctrl   <= ctrl_id;
    end
  end

  assign valid_ex  = r_valid;
  assign pc_ex     = r_pc;
  assign inst_ex   = r_inst;
  assign rf_ra0_ex = r_ra0;
  assign rf_ra1_ex = r_ra1;
  assign rf_wa_ex  = r_wa;
  assign rf_we_ex  = r_we;
  assign mem_re_ex = r_mem_re;
  assign rf_rd0_ex = r_rd0;
  assign rf_rd1_ex = r_rd1;
  assign imm_ex    = r_imm;
  assign ctrl_ex   = r_ctrl;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_flush_cnt;

  // A simultaneous flush and hazard counts as a flush only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= 32'd0;
      r_flush_cnt  <= 32'd0;
    end else if (en) begin
      if (flush)
        r_flush_cnt <= r_flush_cnt + 32'd1;
      else if (w_lu)
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
  assign flush_cnt  = r_flush_cnt;
`endif

endmodule

// File: tb/tb_id_ex_segreg.sv
// Self-checking bench for id_ex_segreg: directed scenarios plus randomized traffic
// checked against a transaction-level model of the EX slot.
module tb_id_ex_segreg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [4:0]  wa;
    logic        we;
    logic        mre;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [31:0] imm;
    logic [15:0] ctrl;
  } ex_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        re0;
    logic        re1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [4:0]  wa;
    logic        we;
    logic        mre;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [31:0] imm;
    logic [15:0] ctrl;
  } id_t;

  logic        clk = 1'b0;
  logic        rst, en, flush;
  logic [31:0] pc_id, inst_id, rf_rd0_id, rf_rd1_id, imm_id;
  logic        rf_re0_id, rf_re1_id, rf_we_id, mem_re_id;
  logic [4:0]  rf_ra0_id, rf_ra1_id, rf_wa_id;
  logic [15:0] ctrl_id;
  logic        valid_ex, rf_we_ex, mem_re_ex, stall_if_id;
  logic [31:0] pc_ex, inst_ex, rf_rd0_ex, rf_rd1_ex, imm_ex;
  logic [4:0]  rf_ra0_ex, rf_ra1_ex, rf_wa_ex;
  logic [15:0] ctrl_ex;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt, flush_cnt;
`endif

  ex_t dut_ex;
  assign dut_ex = {valid_ex, pc_ex, inst_ex, rf_ra0_ex, rf_ra1_ex, rf_wa_ex,
                   rf_we_ex, mem_re_ex, rf_rd0_ex, rf_rd1_ex, imm_ex, ctrl_ex};

  id_ex_segreg dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .pc_id(pc_id), .inst_id(inst_id),
    .rf_re0_id(rf_re0_id), .rf_re1_id(rf_re1_id),
    .rf_ra0_id(rf_ra0_id), .rf_ra1_id(rf_ra1_id), .rf_wa_id(rf_wa_id),
    .rf_we_id(rf_we_id), .mem_re_id(mem_re_id),
    .rf_rd0_id(rf_rd0_id), .rf_rd1_id(rf_rd1_id), .imm_id(imm_id), .ctrl_id(ctrl_id),
    .valid_ex(valid_ex), .pc_ex(pc_ex), .inst_ex(inst_ex),
    .rf_ra0_ex(rf_ra0_ex), .rf_ra1_ex(rf_ra1_ex), .rf_wa_ex(rf_wa_ex),
    .rf_we_ex(rf_we_ex), .mem_re_ex(mem_re_ex),
    .rf_rd0_ex(rf_rd0_ex), .rf_rd1_ex(rf_rd1_ex), .imm_ex(imm_ex), .ctrl_ex(ctrl_ex),
`ifdef ID_EX_PERF_CNT_EN
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
`endif
    .stall_if_id(stall_if_id)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  int   errors = 0;
  int   checks = 0;
  ex_t  m;
  logic [31:0] m_bcnt = 32'd0;
  logic [31:0] m_fcnt = 32'd0;
  id_t  cur;
  logic cur_rst, cur_en, cur_flush;

  function automatic ex_t bubble();
    ex_t b;
    b = '0;
    b.inst = 32'h0000_0013;
    return b;
  endfunction

  // Does the instruction waiting in ID need a value the load in EX has not produced yet?
  function automatic logic model_hazard();
    logic needs;
    needs = (cur.re0 && cur.ra0 == m.wa) || (cur.re1 && cur.ra1 == m.wa);
    return m.valid && m.mre && m.we && (m.wa != 5'd0) && needs;
  endfunction

  function automatic logic model_stall();
    return !cur_rst && cur_en && !cur_flush && model_hazard();
  endfunction

  function automatic id_t rand_id();
    id_t d;
    d.pc   = $urandom;
    d.inst = $urandom;
    d.re0  = 1'($urandom_range(0, 1));
    d.re1  = 1'($urandom_range(0, 1));
    d.ra0  = 5'($urandom_range(0, 3));
    d.ra1  = 5'($urandom_range(0, 3));
    d.wa   = 5'($urandom_range(0, 3));
    d.we   = 1'($urandom_range(0, 3) != 0);
    d.mre  = 1'($urandom_range(0, 1));
    d.rd0  = $urandom;
    d.rd1  = $urandom;
    d.imm  = $urandom;
    d.ctrl = 16'($urandom);
    return d;
  endfunction

  function automatic id_t mk_id(logic [31:0] pc, logic re0, logic [4:0] ra0,
                                logic re1, logic [4:0] ra1, logic [4:0] wa,
                                logic we, logic mre);
    id_t d;
    d = rand_id();
    d.pc = pc; d.re0 = re0; d.ra0 = ra0; d.re1 = re1; d.ra1 = ra1;
    d.wa = wa; d.we = we; d.mre = mre;
    return d;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input id_t d, input logic r, input logic e, input logic f);
    cur = d; cur_rst = r; cur_en = e; cur_flush = f;
    rst = r; en = e; flush = f;
    pc_id = d.pc; inst_id = d.inst; rf_re0_id = d.re0; rf_re1_id = d.re1;
    rf_ra0_id = d.ra0; rf_ra1_id = d.ra1; rf_wa_id = d.wa; rf_we_id = d.we;
    mem_re_id = d.mre; rf_rd0_id = d.rd0; rf_rd1_id = d.rd1; imm_id = d.imm;
    ctrl_id = d.ctrl;
    #1;
  endtask

  // Advance one clock and apply the pipeline rules to the model.
  task automatic tick();
    logic hz;
    hz = model_hazard();
    @(posedge clk);
    if (cur_rst) begin
      m = bubble(); m_bcnt = 0; m_fcnt = 0;
    end else if (cur_en) begin
      if (cur_flush) begin
        m = bubble(); m_fcnt = m_fcnt + 1;
      end else if (hz) begin
        m = bubble(); m_bcnt = m_bcnt + 1;
      end else begin
        m = '{valid: 1'b1, pc: cur.pc, inst: cur.inst, ra0: cur.ra0, ra1: cur.ra1,
              wa: cur.wa, we: cur.we, mre: cur.mre, rd0: cur.rd0, rd1: cur.rd1,
              imm: cur.imm, ctrl: cur.ctrl};
      end
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(rand_id(), 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (i > 0) begin
        checks++;
        if (stall_if_id !== 1'b0) begin
          errors++; $display("FAIL reset_stall: got %b exp 0", stall_if_id);
        end
      end
      tick();
      checks++;
      if (dut_ex !== bubble()) begin
        errors++; $display("FAIL reset_state: got %h exp %h", dut_ex, bubble());
      end
      checks++;
      if (inst_ex !== 32'h0000_0013 || valid_ex !== 1'b0) begin
        errors++; $display("FAIL reset_nop: inst %h valid %b exp 00000013 0", inst_ex, valid_ex);
      end
    end
`ifdef ID_EX_PERF_CNT_EN
    checks++;
    if (bubble_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d exp 0/0", bubble_cnt, flush_cnt);
    end
`endif
  endtask

  task automatic test_capture();
    id_t d;
    d = mk_id(32'h100, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5, 1'b1, 1'b0);
    d.rd0 = 32'hDEAD_BEEF;
    drive(d, 1'b0, 1'b1, 1'b0);
    checks++;
    if (stall_if_id !== 1'b0) begin
      errors++; $display("FAIL capture_stall: got %b exp 0", stall_if_id);
    end
    tick();
    checks++;
    if (pc_ex !== 32'h100 || rf_wa_ex !== 5'd5 || rf_rd0_ex !== 32'hDEAD_BEEF || valid_ex !== 1'b1) begin
      errors++;
      $display("FAIL capture_fields: pc %h wa %0d rd0 %h valid %b exp 00000100 5 deadbeef 1",
               pc_ex, rf_wa_ex, rf_rd0_ex, valid_ex);
    end
    checks++;
    if (dut_ex !== m) begin
      errors++; $display("FAIL capture_all: got %h exp %h", dut_ex, m);
    end
  endtask

  task automatic test_load_use();
    id_t add;
    drive(mk_id(32'h104, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5, 1'b1, 1'b1), 1'b0, 1'b1, 1'b0);
    tick();
    add = mk_id(32'h108, 1'b1, 5'd5, 1'b1, 5'd7, 5'd6, 1'b1, 1'b0);
    drive(add, 1'b0, 1'b1, 1'b0);
    checks++;
    if (stall_if_id !== 1'b1) begin
      errors++; $display("FAIL lu_stall: got %b exp 1", stall_if_id);
    end
    tick();
    checks++;
    if (valid_ex !== 1'b0 || rf_ra0_ex !== 5'd0 || rf_we_ex !== 1'b0 || dut_ex !== bubble()) begin
      errors++; $display("FAIL lu_bubble: got %h exp %h", dut_ex, bubble());
    end
    checks++;
    if (stall_if_id !== 1'b0) begin
      errors++; $display("FAIL lu_one_stall: got %b exp 0", stall_if_id);
    end
    tick();
    checks++;
    if (rf_ra0_ex !== 5'd5 || pc_ex !== 32'h108 || valid_ex !== 1'b1) begin
      errors++; $display("FAIL lu_resume: ra0 %0d pc %h valid %b exp 5 00000108 1", rf_ra0_ex, pc_ex, valid_ex);
    end
`ifdef ID_EX_PERF_CNT_EN
    checks++;
    if (bubble_cnt !== 32'd1 || flush_cnt !== 32'd0) begin
      errors++; $display("FAIL lu_cnt: got %0d/%0d exp 1/0", bubble_cnt, flush_cnt);
    end
`endif
  endtask

  task automatic test_x0_unused();
    drive(mk_id(32'h200, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1), 1'b0, 1'b1, 1'b0);
    tick();
    drive(mk_id(32'h204, 1'b1, 5'd0, 1'b1, 5'd0, 5'd1, 1'b1, 1'b0), 1'b0, 1'b1, 1'b0);
    checks++;
    if (stall_if_id !== 1'b0) begin
      errors++; $display("FAIL x0_stall: got %b exp 0", stall_if_id);
    end
    drive(mk_id(32'h208, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5, 1'b1, 1'b1), 1'b0, 1'b1, 1'b0);
    tick();
    drive(mk_id(32'h20C, 1'b1, 5'd3, 1'b0, 5'd5, 5'd1, 1'b1, 1'b0), 1'b0, 1'b1, 1'b0);
    checks++;
    if (stall_if_id !== 1'b0) begin
      errors++; $display("FAIL unused_src_stall: got %b exp 0", stall_if_id);
    end
    tick();
    checks++;
    if (dut_ex !== m || pc_ex !== 32'h20C) begin
      errors++; $display("FAIL unused_src_capture: got %h exp %h", dut_ex, m);
    end
  endtask

  task automatic test_flush_hazard();
    logic [31:0] b0, f0;
    drive(mk_id(32'h300, 1'b0, 5'd0, 1'b0, 5'd0, 5'd9, 1'b1, 1'b1), 1'b0, 1'b1, 1'b0);
    tick();
    b0 = m_bcnt; f0 = m_fcnt;
    drive(mk_id(32'h304, 1'b0, 5'd0, 1'b1, 5'd9, 5'd2, 1'b1, 1'b0), 1'b0, 1'b1, 1'b1);
    checks++;
    if (stall_if_id !== 1'b0) begin
      errors++; $display("FAIL flush_stall: got %b exp 0", stall_if_id);
    end
    tick();
    checks++;
    if (dut_ex !== bubble()) begin
      errors++; $display("FAIL flush_bubble: got %h exp %h", dut_ex, bubble());
    end
`ifdef ID_EX_PERF_CNT_EN
    checks++;
    if (flush_cnt !== f0 + 32'd1 || bubble_cnt !== b0) begin
      errors++; $display("FAIL flush_cnt: got %0d/%0d exp %0d/%0d", bubble_cnt, flush_cnt, b0, f0 + 1);
    end
`endif
  endtask

  task automatic test_enable_hold();
    id_t dep;
    logic [31:0] b0, f0;
    drive(mk_id(32'h200, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5, 1'b1, 1'b1), 1'b0, 1'b1, 1'b0);
    tick();
    b0 = m_bcnt; f0 = m_fcnt;
    dep = mk_id(32'h204, 1'b1, 5'd5, 1'b0, 5'd0, 5'd6, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(dep, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      checks++;
      if (stall_if_id !== 1'b0) begin
        errors++; $display("FAIL hold_stall: got %b exp 0", stall_if_id);
      end
      tick();
      checks++;
      if (pc_ex !== 32'h200 || valid_ex !== 1'b1 || dut_ex !== m) begin
        errors++; $display("FAIL hold_state: pc %h valid %b exp 00000200 1", pc_ex, valid_ex);
      end
`ifdef ID_EX_PERF_CNT_EN
      checks++;
      if (bubble_cnt !== b0 || flush_cnt !== f0) begin
        errors++; $display("FAIL hold_cnt: got %0d/%0d exp %0d/%0d", bubble_cnt, flush_cnt, b0, f0);
      end
`endif
    end
    drive(dep, 1'b0, 1'b1, 1'b0);
    checks++;
    if (stall_if_id !== 1'b1) begin
      errors++; $display("FAIL hold_resume_stall: got %b exp 1", stall_if_id);
    end
    tick();
    checks++;
    if (dut_ex !== bubble()) begin
      errors++; $display("FAIL hold_resume_bubble: got %h exp %h", dut_ex, bubble());
    end
    tick();
    checks++;
    if (pc_ex !== 32'h204 || valid_ex !== 1'b1) begin
      errors++; $display("FAIL hold_resume_capture: pc %h valid %b exp 00000204 1", pc_ex, valid_ex);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(mk_id(32'h400, 1'b0, 5'd0, 1'b0, 5'd0, 5'd4, 1'b1, 1'b1), 1'b0, 1'b1, 1'b0);
    tick();
    drive(mk_id(32'h404, 1'b1, 5'd4, 1'b0, 5'd0, 5'd1, 1'b1, 1'b0), 1'b1, 1'b1, 1'b0);
    checks++;
    if (stall_if_id !== 1'b0) begin
      errors++; $display("FAIL rst_mid_stall: got %b exp 0", stall_if_id);
    end
    tick();
    checks++;
    if (dut_ex !== bubble()) begin
      errors++; $display("FAIL rst_mid_bubble: got %h exp %h", dut_ex, bubble());
    end
`ifdef ID_EX_PERF_CNT_EN
    checks++;
    if (bubble_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      errors++; $display("FAIL rst_mid_cnt: got %0d/%0d exp 0/0", bubble_cnt, flush_cnt);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(rand_id(), 1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 7) != 0),
            1'($urandom_range(0, 9) == 0));
      checks++;
      if (stall_if_id !== model_stall()) begin
        errors++; $display("FAIL rand_stall[%0d]: got %b exp %b", i, stall_if_id, model_stall());
      end
      tick();
      checks++;
      if (dut_ex !== m) begin
        errors++; $display("FAIL rand_state[%0d]: got %h exp %h", i, dut_ex, m);
      end
`ifdef ID_EX_PERF_CNT_EN
      checks++;
      if (bubble_cnt !== m_bcnt || flush_cnt !== m_fcnt) begin
        errors++; $display("FAIL rand_cnt[%0d]: got %0d/%0d exp %0d/%0d", i, bubble_cnt, flush_cnt, m_bcnt, m_fcnt);
      end
`endif
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    m = bubble();
    @(negedge clk);
    test_reset();
    test_capture();
    test_load_use();
    test_x0_unused();
    test_flush_hazard();
    test_enable_hold();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
